// File: rtl/pingpong_ram_dual.sv
// -----------------------------------------------------------------------------
// pingpong_ram_dual
// Two-bank (ping-pong) buffer between a producer (port A, write side) and a
// consumer (port B, read side). The producer fills one bank while the consumer
// drains the other; ownership of a bank moves across with one-cycle finish
// strobes. Single clock domain, synchronous active-high reset.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset (RAM contents are kept)
//   i_addra    write address inside the current write bank
//   i_wea      write enable (ignored while o_readya is low)
//   i_dina     write data
//   i_finisha  one-cycle strobe: writer has filled the current bank
//   i_addrb    read address inside the current read bank
//   i_finishb  one-cycle strobe: reader has drained the current bank
//   o_readya   current write bank is EMPTY and owned by port A
//   o_doutb    registered read data, one cycle after i_addrb
//   o_readyb   current read bank is FULL and owned by port B
// -----------------------------------------------------------------------------
module pingpong_ram_dual #(
    parameter int AW = 7,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_addra,
    input  logic          i_wea,
    input  logic [DW-1:0] i_dina,
    input  logic          i_finisha,
    input  logic [AW-1:0] i_addrb,
    input  logic          i_finishb,
    output logic          o_readya,
    output logic [DW-1:0] o_doutb,
    output logic          o_readyb
);

    localparam int DEPTH = 2 ** (AW + 1);

    // Both banks live in one array; the bank select is the address MSB.
    logic [DW-1:0] r_mem [0:DEPTH-1];

    logic [1:0]    r_full;
    logic          r_wsel;
    logic          r_rsel;
    logic          r_readya;
    logic          r_readyb;
    logic [DW-1:0] r_doutb;

    logic [1:0]    w_full_nxt;
    logic          w_wsel_nxt;
    logic          w_rsel_nxt;
    logic          w_do_fa;
    logic          w_do_fb;

    // r_readya/r_readyb always equal ~r_full[r_wsel] / r_full[r_rsel];
    // they are kept as flops so the outputs come straight from registers.
    assign o_readya = r_readya;
    assign o_readyb = r_readyb;
    assign o_doutb  = r_doutb;

    // Strobes only count while the matching side owns its bank.
    assign w_do_fa = i_finisha & r_readya;
    assign w_do_fb = i_finishb & r_readyb;

    // Next bank-state: the two strobes always touch different banks
    // (one EMPTY, one FULL), so both updates can be applied together.
    always_comb begin
        w_full_nxt = r_full;
        w_wsel_nxt = r_wsel;
        w_rsel_nxt = r_rsel;
        if (w_do_fa) begin
            w_full_nxt[r_wsel] = 1'b1;
            w_wsel_nxt         = ~r_wsel;
        end else begin
            w_wsel_nxt = r_wsel;
        end
        if (w_do_fb) begin
            w_full_nxt[r_rsel] = 1'b0;
            w_rsel_nxt         = ~r_rsel;
        end else begin
            w_rsel_nxt = r_rsel;
        end
    end

    // Bank ownership registers and the ready flags decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full   <= 2'b00;
            r_wsel   <= 1'b0;
            r_rsel   <= 1'b0;
            r_readya <= 1'b1;
            r_readyb <= 1'b0;
        end else begin
            r_full   <= w_full_nxt;
            r_wsel   <= w_wsel_nxt;
            r_rsel   <= w_rsel_nxt;
            r_readya <= ~w_full_nxt[w_wsel_nxt];
            r_readyb <= w_full_nxt[w_rsel_nxt];
        end
    end

    // Write port: lands in the current write bank, even when finisha is
    // high in the same cycle (the bank is released after this edge).
    always_ff @(posedge clk) begin
        if (!rst && i_wea && r_readya) begin
            r_mem[{r_wsel, i_addra}] <= i_dina;
        end else begin
            r_mem[{r_wsel, i_addra}] <= r_mem[{r_wsel, i_addra}];
        end
    end

    // Read port: unconditional registered read using the pre-edge rsel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_doutb <= {DW{1'b0}};
        end else begin
            r_doutb <= r_mem[{r_rsel, i_addrb}];
        end
    end

endmodule

// File: tb/tb_pingpong_ram_dual.sv
module tb_pingpong_ram_dual;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] addra = 7'd0;
    logic       wea = 1'b0;
    logic [7:0] dina = 8'd0;
    logic       finisha = 1'b0;
    logic [6:0] addrb = 7'd0;
    logic       finishb = 1'b0;
    logic       readya;
    logic [7:0] doutb;
    logic       readyb;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a count of filled banks plus running strobe counts.
    // The write bank is (accepted finisha count mod 2), the read bank is
    // (accepted finishb count mod 2).
    int         m_fills = 0;
    int         m_fa    = 0;
    int         m_fb    = 0;
    logic [7:0] m_mem   [0:1][0:127];
    bit         m_known [0:1][0:127];
    logic [7:0] m_dout  = 8'd0;
    bit         m_dv    = 1'b0;

    pingpong_ram_dual #(.AW(7), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_addra   (addra),
        .i_wea     (wea),
        .i_dina    (dina),
        .i_finisha (finisha),
        .i_addrb   (addrb),
        .i_finishb (finishb),
        .o_readya  (readya),
        .o_doutb   (doutb),
        .o_readyb  (readyb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic tick();
        bit         ra;
        bit         rb;
        int         rbank;
        ra    = (m_fills < 2);
        rb    = (m_fills > 0);
        rbank = m_fb % 2;
        if (rst) begin
            m_fills = 0;
            m_fa    = 0;
            m_fb    = 0;
            m_dout  = 8'd0;
            m_dv    = 1'b1;
        end else begin
            m_dout = m_mem[rbank][addrb];
            m_dv   = rb && m_known[rbank][addrb];
            if (wea && ra) begin
                m_mem[m_fa % 2][addra]   = dina;
                m_known[m_fa % 2][addra] = 1'b1;
            end
            if (finisha && ra) begin
                m_fills++;
                m_fa++;
            end
            if (finishb && rb) begin
                m_fills--;
                m_fb++;
            end
        end
        @(posedge clk);
        #1;
        chk("readya", {31'd0, readya}, {31'd0, (m_fills < 2)});
        chk("readyb", {31'd0, readyb}, {31'd0, (m_fills > 0)});
        if (m_dv) chk("doutb", {24'd0, doutb}, {24'd0, m_dout});
    endtask

    task automatic idle_inputs();
        wea     = 1'b0;
        finisha = 1'b0;
        finishb = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < cycles; k++) tick();
        rst = 1'b0;
    endtask

    task automatic fill(input int n, input logic [7:0] val, input bit rnd);
        for (int i = 0; i < n; i++) begin
            wea   = 1'b1;
            addra = 7'(i);
            dina  = rnd ? 8'($urandom) : val;
            tick();
        end
        wea = 1'b0;
    endtask

    task automatic pulse_fa();
        finisha = 1'b1;
        tick();
        finisha = 1'b0;
    endtask

    task automatic pulse_fb();
        finishb = 1'b1;
        tick();
        finishb = 1'b0;
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            addrb = 7'(i);
            tick();
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 128; a++) begin
                m_mem[b][a]   = 8'd0;
                m_known[b][a] = 1'b0;
            end

        // 1. reset
        do_reset(2);
        chk("rst_readya", {31'd0, readya}, 32'd1);
        chk("rst_readyb", {31'd0, readyb}, 32'd0);
        chk("rst_doutb", {24'd0, doutb}, 32'd0);

        // 2. fill bank 0 with i, release, read back
        for (int i = 0; i < 64; i++) begin
            wea = 1'b1; addra = 7'(i); dina = 8'(i);
            tick();
        end
        wea = 1'b0;
        pulse_fa();
        chk("fill_readyb", {31'd0, readyb}, 32'd1);
        chk("fill_readya", {31'd0, readya}, 32'd1);
        for (int i = 0; i < 64; i++) begin
            addrb = 7'(i);
            tick();
            chk("fill_data", {24'd0, doutb}, i);
        end

        // 3. both banks full, extra write/finisha ignored
        do_reset(1);
        fill(64, 8'hAA, 1'b0);
        pulse_fa();
        fill(64, 8'h55, 1'b0);
        pulse_fa();
        chk("full_readya", {31'd0, readya}, 32'd0);
        wea = 1'b1; addra = 7'd3; dina = 8'hFF;
        tick();
        wea = 1'b0;
        pulse_fa();
        chk("full_ign", {30'd0, dut.r_full}, 32'd3);
        read_n(64);
        addrb = 7'd3;
        tick();
        chk("full_bank0", {24'd0, doutb}, 32'h0AA);
        pulse_fb();
        chk("drain_readya", {31'd0, readya}, 32'd1);
        chk("drain_readyb", {31'd0, readyb}, 32'd1);
        read_n(64);
        chk("bank1_last", {24'd0, doutb}, 32'h055);

        // 4. finishb underflow
        do_reset(1);
        pulse_fb();
        chk("uf_rsel", {31'd0, dut.r_rsel}, 32'd0);
        chk("uf_full", {30'd0, dut.r_full}, 32'd0);

        // 5. simultaneous strobes
        fill(64, 8'h00, 1'b1);
        pulse_fa();
        fill(32, 8'h00, 1'b1);
        finisha = 1'b1; finishb = 1'b1;
        tick();
        finisha = 1'b0; finishb = 1'b0;
        chk("sim_full", {30'd0, dut.r_full}, 32'd2);
        chk("sim_wsel", {31'd0, dut.r_wsel}, 32'd0);
        chk("sim_rsel", {31'd0, dut.r_rsel}, 32'd1);
        read_n(32);

        // 6. reset mid-stream, then 32 streamed frames
        do_reset(1);
        fill(64, 8'h00, 1'b1);
        pulse_fa();
        do_reset(1);
        chk("mid_readyb", {31'd0, readyb}, 32'd0);
        chk("mid_doutb", {24'd0, doutb}, 32'd0);
        for (int f = 0; f < 32; f++) begin
            for (int i = 0; i < 64; i++) begin
                wea = 1'b1; addra = 7'(i); dina = 8'($urandom);
                addrb = 7'(i);
                tick();
            end
            wea = 1'b0;
            finisha = 1'b1; finishb = 1'b1;
            tick();
            finisha = 1'b0; finishb = 1'b0;
            chk("frm_wsel", {31'd0, dut.r_wsel}, (f + 1) % 2);
            for (int g = 0; g < 16; g++) begin
                addrb = 7'($urandom);
                tick();
            end
        end
        read_n(64);
        pulse_fb();

        // Random soak
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wea     = 1'($urandom);
            addra   = 7'($urandom);
            dina    = 8'($urandom);
            finisha = ($urandom_range(0, 24) == 0);
            finishb = ($urandom_range(0, 24) == 0);
            addrb   = 7'($urandom);
            tick();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pingpong_ram_dual.md
Name: pingpong_ram_dual

Overview:
- Two-bank (ping-pong) buffer of 2 × 128 × 8-bit RAM between a producer (port A, write) and a consumer (port B, read).
- The producer fills one bank while the consumer drains the other. Bank ownership passes between the ports with single-cycle finish strobes.
- Single clock domain. Sits between a frame/sample generator and a downstream serializer or DAC feeder.

Parameters:
- AW, 7, address width; each bank is 2^AW words deep.
- DW, 8, data word width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- addra  input  AW  write address within the current write bank.
- wea  input  1  write enable.
- dina  input  DW  write data.
- finisha  input  1  one-cycle strobe: writer has finished the current bank.
- addrb  input  AW  read address within the current read bank.
- finishb  input  1  one-cycle strobe: reader has finished the current bank.
- readya  output  1  current write bank is EMPTY and owned by port A.
- doutb  output  DW  registered read data.
- readyb  output  1  current read bank is FULL and owned by port B.

Behaviour:

State
- Per-bank flag full[0..1].
- Write-bank select wsel and read-bank select rsel, each 1 bit.
- RAM contents are not initialised or cleared by reset.

Reset (rst=1 at a rising edge)
- full = 00, wsel = 0, rsel = 0, doutb = 0.
- Hence readya = 1 and readyb = 0 in the next cycle.

Ready flags
- readya = ~full[wsel]; readyb = full[rsel].
- Both are decoded from registered state only, with no combinational path from inputs.

Write
- On a rising edge with wea=1 and readya=1: bank[wsel][addra] <= dina.
- wea while readya=0 is ignored; memory is unchanged.

finisha
- Sampled every cycle; each high cycle is one event. Callers must pulse it for exactly one cycle.
- If readya=1: full[wsel] <= 1 and wsel <= ~wsel.
- If readya=0: ignored.
- A write in the same cycle as finisha lands in the bank being released.

Read
- Every rising edge: doutb <= bank[rsel][addrb]. Latency is 1 cycle from address to data.
- The read happens regardless of readyb. Data is only meaningful while readyb=1.

finishb
- If readyb=1: full[rsel] <= 0 and rsel <= ~rsel.
- If readyb=0: ignored.
- A read in the same cycle as finishb still uses the old rsel.

Simultaneous events
- finisha and finishb in the same cycle are both applied. They always act on different banks, because one acts on an EMPTY bank and the other on a FULL bank.
- Ready flags for the next cycle reflect both updates.

Boundaries
- Both banks FULL: readya=0; further finisha and wea are ignored until finishb.
- Both banks EMPTY: readyb=0; finishb is ignored.
- Addresses wrap naturally within AW bits; no overflow detection.

Mid-operation reset
- Returns to the reset state at once; any pending full banks are discarded.

Test Plan:
1. Reset: hold rst for 2 cycles -> readya=1, readyb=0, doutb=0x00.
2. Fill and read back:
   - Stimulus: write dina=i to addra=i for i=0..63, pulse finisha, then read addrb=0..63.
   - Required: readyb=1 one cycle after the strobe; readya stays 1 (bank 1 is empty); doutb equals the previous cycle's addrb value (0x00..0x3F).
3. Both banks full:
   - Stimulus: fill bank 0 with 0xAA and pulse finisha; fill bank 1 with 0x55 and pulse finisha.
   - Required: readya=0. An extra wea with 0xFF and an extra finisha are ignored.
   - Then read bank 0 (all 0xAA) and pulse finishb -> readya=1, readyb=1, and reads return 0x55.
4. Underflow: pulse finishb with readyb=0 -> no state change; readya=1, readyb=0, rsel unchanged.
5. Simultaneous strobes:
   - Stimulus: with bank 0 FULL and bank 1 being written, pulse finisha and finishb in the same cycle.
   - Required next cycle: full=10, wsel=0, rsel=1, readya=1, readyb=1.
6. Reset mid-stream:
   - Stimulus: assert rst after one bank is FULL.
   - Required: readyb=0, readya=1, doutb=0x00, and a new frame starts in bank 0.
   - Repeat 32 frames of 64 words with a 16-cycle gap -> no data corruption, and readya/readyb alternate correctly.
